dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: port 0 is the processor MEM stage, port 1 is the debug/loader master.
- Arbitration is round-robin, with an optional lock so a requester can hold the grant for a burst.
- Each winning command is registered for one cycle, then driven onto the dmem port.
- Reads return the word from the memory's asynchronous read path. Writes complete on the memory's synchronous write edge.

---
 rtl/dmem_arb_pkg.sv | 29 ++
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arbiter_rr_arb2.sv | 30 +++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arb_pkg;

    localparam logic PORT_PROC = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    localparam logic [1:0] LOCK_NONE = 2'b00;
    localparam logic [1:0] LOCK_P0   = 2'b01;
    localparam logic [1:0] LOCK_P1   = 2'b10;

    localparam int ADDR_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef logic [1:0] lock_own_t;

    // Command fields that travel with a granted request into the stage.
    typedef struct packed {
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } cmd_meta_t;

    function automatic lock_own_t lock_for(input logic port);
        return port ? LOCK_P1 : LOCK_P0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and dmem-side signals of the data-memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: none on responses; requests are accepted on req & gnt.
interface dmem_arbiter_if #(
    parameter int ADDR_W = dmem_arb_pkg::ADDR_W_DEF,
    parameter int CNT_W  = dmem_arb_pkg::CNT_W_DEF
);
    logic              ip_req0,   ip_req1;
    logic              ip_lock0,  ip_lock1;
    logic [ADDR_W-1:0] ip_addr0,  ip_addr1;
    logic              ip_wr0,    ip_wr1;
    logic [3:0]        ip_mask0,  ip_mask1;
    logic [31:0]       ip_wdata0, ip_wdata1;

    logic              op_gnt0,       op_gnt1;
    logic              op_rsp_valid0, op_rsp_valid1;
    logic [31:0]       op_rsp_data0,  op_rsp_data1;

    logic [ADDR_W-1:0] op_dmem_addr;
    logic              op_dmem_wr;
    logic [3:0]        op_dmem_mask;
    logic [31:0]       op_dmem_wdata;
    logic              op_dmem_rd;
    logic              ip_dmem_valid;
    logic [31:0]       ip_dmem_rdata;

    logic [CNT_W-1:0]  op_gnt_cnt0, op_gnt_cnt1;

    // Arbiter side.
    modport slave (
        input  ip_req0, ip_req1, ip_lock0, ip_lock1, ip_addr0, ip_addr1,
               ip_wr0, ip_wr1, ip_mask0, ip_mask1, ip_wdata0, ip_wdata1,
               ip_dmem_valid, ip_dmem_rdata,
        output op_gnt0, op_gnt1, op_rsp_valid0, op_rsp_valid1,
               op_rsp_data0, op_rsp_data1,
               op_dmem_addr, op_dmem_wr, op_dmem_mask, op_dmem_wdata, op_dmem_rd,
               op_gnt_cnt0, op_gnt_cnt1
    );

    // Requesters plus memory, viewed from outside the arbiter.
    modport master (
        output ip_req0, ip_req1, ip_lock0, ip_lock1, ip_addr0, ip_addr1,
               ip_wr0, ip_wr1, ip_mask0, ip_mask1, ip_wdata0, ip_wdata1,
               ip_dmem_valid, ip_dmem_rdata,
        input  op_gnt0, op_gnt1, op_rsp_valid0, op_rsp_valid1,
               op_rsp_data0, op_rsp_data1,
               op_dmem_addr, op_dmem_wr, op_dmem_mask, op_dmem_wdata, op_dmem_rd,
               op_gnt_cnt0, op_gnt_cnt1
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant with an optional lock holding the current owner.
// Latency: combinational.
// Backpressure: none; a locked owner that drops req releases the lock this cycle.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  lock_own_t  lock_own,
    input  logic       rr_last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (lock_own == LOCK_P0 && req[0]) begin
            gnt = 2'b01;
        end else if (lock_own == LOCK_P1 && req[1]) begin
            gnt = 2'b10;
        end else begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Tie goes to the port that did not win last time.
                2'b11:   gnt = (rr_last == PORT_DBG) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the MEM stage (port 0) and debug/loader (port 1).
// Latency: command registered once, driven to dmem and answered 1 cycle after accept.
// Backpressure: requesters stall on gnt; responses cannot be stalled.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
)(
    input  logic           clk,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [1:0]        acc;
    logic              acc_any;
    logic              acc_id;

    logic              rr_last;
    lock_own_t         lock_own;

    logic              stg_valid;
    logic              stg_id;
    logic [ADDR_W-1:0] stg_addr;
    cmd_meta_t         stg_meta;

    logic [ADDR_W-1:0] win_addr;
    cmd_meta_t         win_meta;
    logic              win_lock;

    logic [CNT_W-1:0]  gnt_cnt0;
    logic [CNT_W-1:0]  gnt_cnt1;

    logic              rsp_valid0;
    logic              rsp_valid1;

    assign req = {bus.ip_req1, bus.ip_req0};

    rr_arb2 u_rr_arb2 (
        .req      (req),
        .lock_own (lock_own),
        .rr_last  (rr_last),
        .gnt      (gnt)
    );

    assign acc     = req & gnt;
    assign acc_any = |acc;
    assign acc_id  = acc[1];

    assign bus.op_gnt0 = gnt[0];
    assign bus.op_gnt1 = gnt[1];

    always_comb begin
        win_addr       = bus.ip_addr0;
        win_meta.wr    = bus.ip_wr0;
        win_meta.mask  = bus.ip_mask0;
        win_meta.wdata = bus.ip_wdata0;
        win_lock       = bus.ip_lock0;
        if (acc_id) begin
            win_addr       = bus.ip_addr1;
            win_meta.wr    = bus.ip_wr1;
            win_meta.mask  = bus.ip_mask1;
            win_meta.wdata = bus.ip_wdata1;
            win_lock       = bus.ip_lock1;
        end
    end

    // Stage, round-robin pointer and lock owner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid <= 1'b0;
            stg_id    <= 1'b0;
            stg_addr  <= '0;
            stg_meta  <= '0;
            rr_last   <= 1'b1;
            lock_own  <= LOCK_NONE;
        end else begin
            stg_valid <= acc_any;
            if (acc_any) begin
                stg_id   <= acc_id;
                stg_addr <= win_addr;
                stg_meta <= win_meta;
                rr_last  <= acc_id;
                lock_own <= win_lock ? lock_for(acc_id) : LOCK_NONE;
            end else begin
                lock_own <= LOCK_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (acc[0] && gnt_cnt0 != {CNT_W{1'b1}}) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (acc[1] && gnt_cnt1 != {CNT_W{1'b1}}) gnt_cnt1 <= gnt_cnt1 + 1'b1;
        end
    end

    assign bus.op_gnt_cnt0 = gnt_cnt0;
    assign bus.op_gnt_cnt1 = gnt_cnt1;

    // dmem drive is forced to zero whenever the stage is empty, including under reset.
    assign bus.op_dmem_addr  = stg_valid ? stg_addr       : '0;
    assign bus.op_dmem_mask  = stg_valid ? stg_meta.mask  : 4'b0;
    assign bus.op_dmem_wdata = stg_valid ? stg_meta.wdata : 32'b0;
    assign bus.op_dmem_wr    = stg_valid &  stg_meta.wr;
    assign bus.op_dmem_rd    = stg_valid & ~stg_meta.wr;

    assign rsp_valid0 = stg_valid & (stg_id == PORT_PROC) & bus.ip_dmem_valid;
    assign rsp_valid1 = stg_valid & (stg_id == PORT_DBG)  & bus.ip_dmem_valid;

    assign bus.op_rsp_valid0 = rsp_valid0;
    assign bus.op_rsp_valid1 = rsp_valid1;
    assign bus.op_rsp_data0  = (rsp_valid0 && !stg_meta.wr) ? bus.ip_dmem_rdata : 32'b0;
    assign bus.op_rsp_data1  = (rsp_valid1 && !stg_meta.wr) ? bus.ip_dmem_rdata : 32'b0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small async-read / sync-write memory model.
module tb_dmem_arbiter;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_fail;

    logic [31:0] mem [0:63];

    dmem_arbiter_if #(.ADDR_W(32), .CNT_W(16)) bus ();

    dmem_arbiter #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ip_dmem_rdata = mem[bus.op_dmem_addr[7:2]];
    assign bus.ip_dmem_valid = bus.op_dmem_rd | bus.op_dmem_wr;

    always @(posedge clk) begin
        if (bus.op_dmem_wr) begin
            for (int b = 0; b < 4; b++)
                if (bus.op_dmem_mask[b])
                    mem[bus.op_dmem_addr[7:2]][8*b +: 8] <= bus.op_dmem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ip_req0 = 0; bus.ip_req1 = 0; bus.ip_lock0 = 0; bus.ip_lock1 = 0;
        bus.ip_addr0 = 0; bus.ip_addr1 = 0; bus.ip_wr0 = 0; bus.ip_wr1 = 0;
        bus.ip_mask0 = 0; bus.ip_mask1 = 0; bus.ip_wdata0 = 0; bus.ip_wdata1 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic p0_cmd(input logic wr, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] wdata);
        bus.ip_req0 = 1; bus.ip_wr0 = wr; bus.ip_addr0 = addr;
        bus.ip_mask0 = mask; bus.ip_wdata0 = wdata;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 64; i++) mem[i] <= i;
        mem[4]  <= 32'hDEADBEEF;
        mem[8]  <= 32'h11223344;
        mem[9]  <= 32'h55667788;
        mem[10] <= 32'h0A0A0A0A;
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_gnt0", bus.op_gnt0, 0);
        chk("rst_gnt1", bus.op_gnt1, 0);
        chk("rst_dmem_rd", bus.op_dmem_rd, 0);
        chk("rst_dmem_wr", bus.op_dmem_wr, 0);
        chk("rst_rsp_valid0", bus.op_rsp_valid0, 0);
        chk("rst_cnt0", bus.op_gnt_cnt0, 0);
        bus.ip_req0 = 1; bus.ip_req1 = 1;
        #1;
        chk("rst_tie_gnt0", bus.op_gnt0, 1);
        chk("rst_tie_gnt1", bus.op_gnt1, 0);
        idle_inputs();
        reset_n = 1'b1;
        #1;

        // Single read, 1-cycle latency
        p0_cmd(0, 32'h10, 4'hF, 0);
        #1;
        chk("rd_gnt0", bus.op_gnt0, 1);
        tick();
        idle_inputs();
        #1;
        chk("rd_dmem_rd", bus.op_dmem_rd, 1);
        chk("rd_dmem_addr", bus.op_dmem_addr, 32'h10);
        chk("rd_rsp_valid0", bus.op_rsp_valid0, 1);
        chk("rd_rsp_data0", bus.op_rsp_data0, 32'hDEADBEEF);
        chk("rd_rsp_valid1", bus.op_rsp_valid1, 0);
        chk("rd_cnt0", bus.op_gnt_cnt0, 1);
        tick();
        chk("rd_idle_rd", bus.op_dmem_rd, 0);
        chk("rd_idle_rsp0", bus.op_rsp_valid0, 0);

        // Round-robin, both requesting without lock
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.ip_req0 = 1; bus.ip_req1 = 1;
            bus.ip_addr0 = 32'h0; bus.ip_addr1 = 32'h4;
            #1;
            chk($sformatf("rr_gnt0_%0d", i), bus.op_gnt0, (i % 2 == 0));
            chk($sformatf("rr_gnt1_%0d", i), bus.op_gnt1, (i % 2 == 1));
            tick();
        end
        idle_inputs();
        #1;
        chk("rr_cnt0", bus.op_gnt_cnt0, 3);
        chk("rr_cnt1", bus.op_gnt_cnt1, 3);
        tick();

        // Lock: port 1 holds grant for 3 accepts while port 0 requests
        do_reset();
        p0_cmd(0, 32'h0, 4'hF, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.ip_req1 = 1; bus.ip_lock1 = 1; bus.ip_addr1 = 32'h10;
            #1;
            chk($sformatf("lk_gnt1_%0d", i), bus.op_gnt1, 1);
            chk($sformatf("lk_gnt0_%0d", i), bus.op_gnt0, 0);
            tick();
        end
        bus.ip_req1 = 0; bus.ip_lock1 = 0;
        #1;
        chk("lk_release_gnt0", bus.op_gnt0, 1);
        chk("lk_release_gnt1", bus.op_gnt1, 0);
        chk("lk_rsp_valid1", bus.op_rsp_valid1, 1);
        chk("lk_rsp_data1", bus.op_rsp_data1, 32'hDEADBEEF);
        chk("lk_cnt1", bus.op_gnt_cnt1, 3);
        tick();
        idle_inputs();
        tick();

        // Masked write then read-after-write, and a mask-0 no-op write
        p0_cmd(1, 32'h20, 4'b0001, 32'hCAFEBAA5);
        tick();
        p0_cmd(0, 32'h20, 4'hF, 0);
        #1;
        chk("raw_dmem_wr", bus.op_dmem_wr, 1);
        chk("raw_dmem_mask", bus.op_dmem_mask, 4'b0001);
        chk("raw_wr_rsp_valid0", bus.op_rsp_valid0, 1);
        chk("raw_wr_rsp_data0", bus.op_rsp_data0, 0);
        tick();
        p0_cmd(1, 32'h24, 4'b0000, 32'hFFFFFFFF);
        #1;
        chk("raw_dmem_rd", bus.op_dmem_rd, 1);
        chk("raw_rd_data0", bus.op_rsp_data0, 32'h112233A5);
        tick();
        p0_cmd(0, 32'h24, 4'hF, 0);
        #1;
        chk("m0_dmem_wr", bus.op_dmem_wr, 1);
        chk("m0_rsp_valid0", bus.op_rsp_valid0, 1);
        tick();
        idle_inputs();
        #1;
        chk("m0_rd_data0", bus.op_rsp_data0, 32'h55667788);
        tick();

        // Reset while a write is staged
        p0_cmd(1, 32'h28, 4'hF, 32'h55555555);
        tick();
        idle_inputs();
        #1;
        chk("mr_staged_wr", bus.op_dmem_wr, 1);
        reset_n = 1'b0;
        #1;
        chk("mr_wr_drop", bus.op_dmem_wr, 0);
        chk("mr_rsp_valid0", bus.op_rsp_valid0, 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("mr_mem_unchanged", mem[10], 32'h0A0A0A0A);
        chk("mr_post_wr", bus.op_dmem_wr, 0);
        chk("mr_post_rsp0", bus.op_rsp_valid0, 0);
        chk("mr_post_cnt0", bus.op_gnt_cnt0, 0);
        bus.ip_req0 = 1; bus.ip_req1 = 1;
        #1;
        chk("mr_first_gnt0", bus.op_gnt0, 1);
        chk("mr_first_gnt1", bus.op_gnt1, 0);
        tick();
        idle_inputs();
        tick();

        // Counter saturation
        do_reset();
        p0_cmd(0, 32'h0, 4'hF, 0);
        repeat (65534) tick();
        chk("sat_cnt0_fffe", bus.op_gnt_cnt0, 16'hFFFE);
        tick();
        chk("sat_cnt0_ffff", bus.op_gnt_cnt0, 16'hFFFF);
        repeat (3) tick();
        chk("sat_cnt0_hold", bus.op_gnt_cnt0, 16'hFFFF);
        chk("sat_cnt1", bus.op_gnt_cnt1, 0);
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
